// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcode encoding and shared datapath constants.
package alu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_MUL = 3'b010,
    ALU_DIV = 3'b011,
    ALU_ASR = 3'b100,
    ALU_LSR = 3'b101,
    ALU_LSL = 3'b110,
    ALU_AND = 3'b111
  } alu_op_t;
  localparam int WIDTH_DEF = 16;
  localparam logic [15:0] DIV_ZERO_RESULT = 16'hFFFF;
endpackage

// File: rtl/alu.sv
// alu: combinational scalar ALU with zero/negative status.
module alu import alu_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] C,
  output logic             flagZ,
  output logic             flagN
);
  always_comb begin
    case (alu_op_t'(sel))
      ALU_ADD: C = A + B;
      ALU_SUB: C = A - B;
      ALU_MUL: C = A * B;
      ALU_DIV: C = (B == '0) ? DIV_ZERO_RESULT[WIDTH-1:0] : A / B;
      ALU_ASR: C = $signed(A) >>> B[3:0];
      ALU_LSR: C = A >> B[3:0];
      ALU_LSL: C = A << B[3:0];
      default: C = A & B;
    endcase
  end
  assign flagZ = (C == '0);
  assign flagN = C[WIDTH-1];
endmodule

// File: rtl/operand_forward.sv
// operand_forward: picks one source operand from r0, EX/MEM, writeback or register file.
module operand_forward #(
  parameter int WIDTH = 16,
  parameter int RA_W  = 4
) (
  input  logic [RA_W-1:0]  i_addr,
  input  logic [WIDTH-1:0] i_rf_val,
  input  logic             i_ex_wr,
  input  logic [RA_W-1:0]  i_ex_rd,
  input  logic [WIDTH-1:0] i_ex_val,
  input  logic             i_wb_wr,
  input  logic [RA_W-1:0]  i_wb_rd,
  input  logic [WIDTH-1:0] i_wb_val,
  output logic [WIDTH-1:0] o_val
);
  // The newest producer (EX/MEM) takes priority over the older writeback value.
  assign o_val = (i_addr == '0) ? '0 :
                 (i_ex_wr && i_ex_rd == i_addr) ? i_ex_val :
                 (i_wb_wr && i_wb_rd == i_addr) ? i_wb_val : i_rf_val;
endmodule

// File: rtl/scalar_execute_stage.sv
// scalar_execute_stage: forwarding, ALU and EX/MEM register with Z/N flags.
module scalar_execute_stage import alu_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int RA_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [RA_W-1:0]  in_rs1_addr,
  input  logic [RA_W-1:0]  in_rs2_addr,
  input  logic [WIDTH-1:0] in_rs1_val,
  input  logic [WIDTH-1:0] in_rs2_val,
  input  logic             in_use_imm,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [2:0]       in_alu_sel,
  input  logic [RA_W-1:0]  in_rd_addr,
  input  logic             in_reg_write,
  input  logic             in_set_flags,
  input  logic             stall,
  input  logic             flush,
  input  logic             wb_reg_write,
  input  logic [RA_W-1:0]  wb_rd_addr,
  input  logic [WIDTH-1:0] wb_value,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result,
  output logic [RA_W-1:0]  out_rd_addr,
  output logic             out_reg_write,
  output logic             out_div_zero,
  output logic             flag_z,
  output logic             flag_n
);
  logic [WIDTH-1:0] w_a, w_fwd_b, w_b, w_c;
  logic             w_z, w_n, w_ex_wr, w_div_zero;
  logic             r_valid, r_reg_write, r_div_zero, r_flag_z, r_flag_n;
  logic [WIDTH-1:0] r_result;
  logic [RA_W-1:0]  r_rd_addr;
  assign w_ex_wr = r_valid & r_reg_write;
  operand_forward #(.WIDTH(WIDTH), .RA_W(RA_W)) u_fwd_a (
    .i_addr(in_rs1_addr), .i_rf_val(in_rs1_val),
    .i_ex_wr(w_ex_wr), .i_ex_rd(r_rd_addr), .i_ex_val(r_result),
    .i_wb_wr(wb_reg_write), .i_wb_rd(wb_rd_addr), .i_wb_val(wb_value),
    .o_val(w_a)
  );
  operand_forward #(.WIDTH(WIDTH), .RA_W(RA_W)) u_fwd_b (
    .i_addr(in_rs2_addr), .i_rf_val(in_rs2_val),
    .i_ex_wr(w_ex_wr), .i_ex_rd(r_rd_addr), .i_ex_val(r_result),
    .i_wb_wr(wb_reg_write), .i_wb_rd(wb_rd_addr), .i_wb_val(wb_value),
    .o_val(w_fwd_b)
  );
  assign w_b = in_use_imm ? in_imm : w_fwd_b;
  alu #(.WIDTH(WIDTH)) u_alu (
    .A(w_a), .B(w_b), .sel(in_alu_sel), .C(w_c), .flagZ(w_z), .flagN(w_n)
  );
  assign w_div_zero = in_valid & (alu_op_t'(in_alu_sel) == ALU_DIV) & (w_b == '0);
  // Flush outranks stall; a held slot keeps feeding the forwarding paths.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_result    <= '0;
      r_rd_addr   <= '0;
      r_reg_write <= 1'b0;
      r_div_zero  <= 1'b0;
      r_flag_z    <= 1'b0;
      r_flag_n    <= 1'b0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_div_zero  <= 1'b0;
    end else if (!stall) begin
      r_valid     <= in_valid;
      r_result    <= w_c;
      r_rd_addr   <= in_rd_addr;
      r_reg_write <= in_reg_write & in_valid;
      r_div_zero  <= w_div_zero;
      if (in_valid && in_set_flags) begin
        r_flag_z <= w_z;
        r_flag_n <= w_n;
      end
    end
  end
  assign out_valid     = r_valid;
  assign out_result    = r_result;
  assign out_rd_addr   = r_rd_addr;
  assign out_reg_write = r_reg_write;
  assign out_div_zero  = r_div_zero;
  assign flag_z        = r_flag_z;
  assign flag_n        = r_flag_n;
endmodule

// File: tb/tb_scalar_execute_stage.sv
// tb_scalar_execute_stage: directed vector table plus random program against a sequential register model.
module tb_scalar_execute_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, in_use_imm, in_reg_write, in_set_flags, stall, flush, wb_reg_write;
  logic [3:0]  in_rs1_addr, in_rs2_addr, in_rd_addr, wb_rd_addr;
  logic [15:0] in_rs1_val, in_rs2_val, in_imm, wb_value;
  logic [2:0]  in_alu_sel;
  logic        out_valid, out_reg_write, out_div_zero, flag_z, flag_n;
  logic [15:0] out_result;
  logic [3:0]  out_rd_addr;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int v, s, r1, v1, r2, v2, ui, im, rd, rw, sf, st, fl, ww, wr, wv;
    int ev, erw, er, erd, edz, ez, en;
  } vec_t;
  vec_t tbl[23];

  logic [15:0] arch[16];
  logic [15:0] rf[16];
  logic        m_v, m_rw, m_dz, m_z, m_n, m_wb_rw;
  logic [15:0] m_res, m_wb_val, ea, eb, er;
  logic [3:0]  m_rd, m_wb_rd;
  logic        edz;

  scalar_execute_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_use_imm(in_use_imm), .in_imm(in_imm), .in_alu_sel(in_alu_sel),
    .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write), .in_set_flags(in_set_flags),
    .stall(stall), .flush(flush),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_value(wb_value),
    .out_valid(out_valid), .out_result(out_result), .out_rd_addr(out_rd_addr),
    .out_reg_write(out_reg_write), .out_div_zero(out_div_zero),
    .flag_z(flag_z), .flag_n(flag_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int v, s, r1, v1, r2, v2, ui, im, rd, rw, sf, st, fl,
                              ww, wr, wv, ev, erw, er, erd, edz_i, ez, en);
    vec_t t;
    t.v = v; t.s = s; t.r1 = r1; t.v1 = v1; t.r2 = r2; t.v2 = v2; t.ui = ui; t.im = im;
    t.rd = rd; t.rw = rw; t.sf = sf; t.st = st; t.fl = fl; t.ww = ww; t.wr = wr; t.wv = wv;
    t.ev = ev; t.erw = erw; t.er = er; t.erd = erd; t.edz = edz_i; t.ez = ez; t.en = en;
    return t;
  endfunction

  function automatic logic [15:0] ref_alu(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b);
    int sa;
    int unsigned k;
    sa = $signed(a);
    k = int'(b % 16);
    case (s)
      3'd0: return 16'(int'(a) + int'(b));
      3'd1: return 16'(int'(a) - int'(b));
      3'd2: return 16'(longint'(a) * longint'(b));
      3'd3: return (b == 16'd0) ? 16'hFFFF : 16'(int'(a) / int'(b));
      3'd4: return 16'(sa >>> k);
      3'd5: return 16'(int'(a) / (1 << k));
      3'd6: return 16'(int'(a) * (1 << k));
      default: return a & b;
    endcase
  endfunction

  task automatic idle_inputs();
    in_valid = 0; in_rs1_addr = 0; in_rs2_addr = 0; in_rs1_val = 0; in_rs2_val = 0;
    in_use_imm = 0; in_imm = 0; in_alu_sel = 0; in_rd_addr = 0; in_reg_write = 0;
    in_set_flags = 0; stall = 0; flush = 0; wb_reg_write = 0; wb_rd_addr = 0; wb_value = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 16'(out_valid), 16'd0);
    chk({tag, "_result"}, out_result, 16'd0);
    chk({tag, "_rd"}, 16'(out_rd_addr), 16'd0);
    chk({tag, "_reg_write"}, 16'(out_reg_write), 16'd0);
    chk({tag, "_div_zero"}, 16'(out_div_zero), 16'd0);
    chk({tag, "_flag_z"}, 16'(flag_z), 16'd0);
    chk({tag, "_flag_n"}, 16'(flag_n), 16'd0);
  endtask

  task automatic apply(input int idx, input vec_t t);
    string p;
    p = $sformatf("vec%0d", idx);
    @(negedge clk);
    in_valid = 1'(t.v); in_alu_sel = 3'(t.s);
    in_rs1_addr = 4'(t.r1); in_rs1_val = 16'(t.v1);
    in_rs2_addr = 4'(t.r2); in_rs2_val = 16'(t.v2);
    in_use_imm = 1'(t.ui); in_imm = 16'(t.im);
    in_rd_addr = 4'(t.rd); in_reg_write = 1'(t.rw); in_set_flags = 1'(t.sf);
    stall = 1'(t.st); flush = 1'(t.fl);
    wb_reg_write = 1'(t.ww); wb_rd_addr = 4'(t.wr); wb_value = 16'(t.wv);
    @(posedge clk);
    #1;
    chk({p, "_valid"}, 16'(out_valid), 16'(t.ev));
    chk({p, "_reg_write"}, 16'(out_reg_write), 16'(t.erw));
    chk({p, "_flag_z"}, 16'(flag_z), 16'(t.ez));
    chk({p, "_flag_n"}, 16'(flag_n), 16'(t.en));
    if (t.ev != 0) begin
      chk({p, "_result"}, out_result, 16'(t.er));
      chk({p, "_rd"}, 16'(out_rd_addr), 16'(t.erd));
      chk({p, "_div_zero"}, 16'(out_div_zero), 16'(t.edz));
    end
  endtask

  initial begin
    //          v s  r1 v1  r2 v2  ui im  rd rw sf st fl ww wr wv      ev erw er     erd dz z n
    tbl[0]  = mk(1,0, 1, 8,  2, 5,  0, 0,  1, 1, 0, 0, 0, 0, 0, 0,     1, 1, 13,    1, 0, 0, 0);
    tbl[1]  = mk(1,1, 6,10,  7, 3,  0, 0,  2, 1, 1, 0, 0, 0, 0, 0,     1, 1, 7,     2, 0, 0, 0);
    tbl[2]  = mk(1,2, 2, 0,  0, 0,  1, 6,  3, 1, 0, 0, 0, 1, 1, 13,    1, 1, 42,    3, 0, 0, 0);
    tbl[3]  = mk(1,7, 2, 0,  0, 0,  1,15,  4, 1, 0, 0, 0, 1, 2, 7,     1, 1, 7,     4, 0, 0, 0);
    tbl[4]  = mk(1,0, 8,20,  0,123, 0, 0,  5, 1, 0, 0, 0, 1, 3, 42,    1, 1, 20,    5, 0, 0, 0);
    tbl[5]  = mk(1,3, 5, 0,  0, 0,  1, 4,  6, 1, 0, 0, 0, 1, 5, 99,    1, 1, 5,     6, 0, 0, 0);
    tbl[6]  = mk(1,0, 9,50,  0, 0,  1, 1,  0, 1, 0, 0, 0, 1, 5, 20,    1, 1, 51,    0, 0, 0, 0);
    tbl[7]  = mk(1,0, 0,77,  0, 0,  1, 3,  6, 1, 0, 0, 0, 1, 0, 88,    1, 1, 3,     6, 0, 0, 0);
    tbl[8]  = mk(1,1,11, 3, 12, 5,  0, 0,  8, 1, 1, 0, 0, 0, 0, 0,     1, 1, 65534, 8, 0, 0, 1);
    tbl[9]  = mk(1,1,11, 3, 12, 3,  0, 0,  8, 1, 1, 0, 0, 1, 8, 65534, 1, 1, 0,     8, 0, 1, 0);
    tbl[10] = mk(1,3,11,20, 12, 0,  0, 0,  9, 1, 1, 0, 0, 0, 0, 0,     1, 1, 65535, 9, 1, 0, 1);
    tbl[11] = mk(1,0,11, 0, 12, 0,  0, 0, 10, 1, 0, 0, 0, 0, 0, 0,     1, 1, 0,    10, 0, 0, 1);
    tbl[12] = mk(1,4,13,32,  0, 0,  1, 2,  7, 1, 0, 0, 0, 0, 0, 0,     1, 1, 8,     7, 0, 0, 1);
    tbl[13] = mk(1,1,13, 1, 14, 1,  0, 0, 11, 1, 1, 1, 0, 0, 0, 0,     1, 1, 8,     7, 0, 0, 1);
    tbl[14] = tbl[13];
    tbl[15] = tbl[13];
    tbl[16] = mk(1,1,13, 3, 14, 3,  0, 0, 12, 1, 1, 1, 1, 0, 0, 0,     0, 0, 0,     0, 0, 0, 1);
    tbl[17] = mk(1,0,13,40,  0, 0,  1, 2,  9, 1, 0, 0, 0, 0, 0, 0,     1, 1, 42,    9, 0, 0, 1);
    tbl[18] = mk(1,0, 9, 0,  0, 0,  1, 1, 10, 1, 0, 1, 0, 0, 0, 0,     1, 1, 42,    9, 0, 0, 1);
    tbl[19] = mk(1,0, 9, 0,  0, 0,  1, 1, 10, 1, 0, 0, 0, 0, 0, 0,     1, 1, 43,   10, 0, 0, 1);
    tbl[20] = mk(1,6, 1, 4,  3, 0,  1, 2, 11, 1, 0, 0, 0, 1, 3, 100,   1, 1, 16,   11, 0, 0, 1);
    tbl[21] = mk(1,5, 1,32,  3, 0,  1, 2, 12, 1, 0, 0, 0, 1, 3, 100,   1, 1, 8,    12, 0, 0, 1);
    tbl[22] = mk(0,1,13, 3, 14, 3,  0, 0, 13, 1, 1, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0, 1);

    idle_inputs();
    #1 rst = 1'b1;
    #1 chk_all_zero("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 23; i++) apply(i, tbl[i]);

    // Reset asserted between edges while a stalled op waits
    @(negedge clk);
    in_valid = 1; in_alu_sel = 3'd0; in_rs1_addr = 4'd1; in_rs1_val = 16'd8;
    in_rs2_addr = 4'd2; in_rs2_val = 16'd5; in_use_imm = 0; in_rd_addr = 4'd1;
    in_reg_write = 1; in_set_flags = 0; stall = 1; flush = 0; wb_reg_write = 0;
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0; stall = 0;
    @(posedge clk);
    #1;
    chk("post_rst_valid", 16'(out_valid), 16'd1);
    chk("post_rst_result", out_result, 16'd13);

    // Random program: the model keeps sequential register state; DUT sees a lagging register file
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rf[i] = 16'($urandom);
      arch[i] = (i == 0) ? 16'd0 : rf[i];
    end
    m_v = 0; m_rw = 0; m_dz = 0; m_z = 0; m_n = 0; m_res = 0; m_rd = 0;
    m_wb_rw = 0; m_wb_rd = 0; m_wb_val = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 9) != 0);
      in_alu_sel = 3'($urandom_range(0, 7));
      in_rs1_addr = 4'($urandom_range(0, 4));
      in_rs2_addr = 4'($urandom_range(0, 4));
      in_use_imm = ($urandom_range(0, 3) == 0);
      in_imm = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
      in_rd_addr = 4'($urandom_range(0, 4));
      in_reg_write = ($urandom_range(0, 4) != 0);
      in_set_flags = 1'($urandom_range(0, 1));
      stall = ($urandom_range(0, 6) == 0);
      flush = ($urandom_range(0, 9) == 0);
      in_rs1_val = rf[in_rs1_addr];
      in_rs2_val = rf[in_rs2_addr];
      wb_reg_write = m_wb_rw;
      wb_rd_addr = m_wb_rw ? m_wb_rd : 4'($urandom);
      wb_value = m_wb_rw ? m_wb_val : 16'($urandom);
      ea = (in_rs1_addr == 0) ? 16'd0 : arch[in_rs1_addr];
      eb = in_use_imm ? in_imm : ((in_rs2_addr == 0) ? 16'd0 : arch[in_rs2_addr]);
      er = ref_alu(in_alu_sel, ea, eb);
      edz = in_valid && in_alu_sel == 3'd3 && eb == 16'd0;
      @(posedge clk);
      if (m_wb_rw) rf[m_wb_rd] = m_wb_val;
      m_wb_rw = (stall && !flush) ? 1'b0 : m_rw;
      m_wb_rd = m_rd;
      m_wb_val = m_res;
      if (flush) begin
        m_v = 0; m_rw = 0; m_dz = 0;
      end else if (!stall) begin
        m_v = in_valid; m_rw = in_valid & in_reg_write; m_res = er; m_rd = in_rd_addr; m_dz = edz;
        if (in_valid && in_set_flags) begin
          m_z = (er == 16'd0);
          m_n = er[15];
        end
        if (in_valid && in_reg_write && in_rd_addr != 0) arch[in_rd_addr] = er;
      end
      #1;
      chk($sformatf("rnd%0d_valid", c), 16'(out_valid), 16'(m_v));
      chk($sformatf("rnd%0d_reg_write", c), 16'(out_reg_write), 16'(m_rw));
      chk($sformatf("rnd%0d_flag_z", c), 16'(flag_z), 16'(m_z));
      chk($sformatf("rnd%0d_flag_n", c), 16'(flag_n), 16'(m_n));
      if (m_v) begin
        chk($sformatf("rnd%0d_result", c), out_result, m_res);
        chk($sformatf("rnd%0d_rd", c), 16'(out_rd_addr), 16'(m_rd));
        chk($sformatf("rnd%0d_div_zero", c), 16'(out_div_zero), 16'(m_dz));
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
